alu_core: RTL and testbench

Registered, clock-enabled ALU that answers the operand/command interface used by the ALU driver and monitor: it samples `ce`, `mode`, `cmd`, `cin`, `inp_valid`, `opa` and `opb` on `clk`, and returns `res` plus status flags one cycle later. Two-operand commands that arrive with only one operand valid are held in a 16-cycle operand-wait state machine until the missing operand arrives or the wait times out. This is the design under test behind the ALU UVM environment.

---
 rtl/alu_core.sv | 204 ++++++++++++++++++++
 tb/tb_alu_core.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered, clock-enabled ALU with a 16-edge operand-wait FSM for
// two-operand commands that arrive with only one operand valid.
module alu_core #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  mode,
   input  logic                  cin,
   input  logic [1:0]            inp_valid,
   input  logic [CMD_WIDTH-1:0]  cmd,
   input  logic [DATA_WIDTH-1:0] opa,
   input  logic [DATA_WIDTH-1:0] opb,
   output logic [DATA_WIDTH:0]   res,
   output logic                  oflow,
   output logic                  cout,
   output logic                  g,
   output logic                  l,
   output logic                  e,
   output logic                  err
);

   localparam int W  = DATA_WIDTH;
   localparam int LW = $clog2(DATA_WIDTH);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t               state, state_nx;
   logic [3:0]           cnt, cnt_nx;
   logic [CMD_WIDTH-1:0] l_cmd;
   logic                 l_mode, l_cin;
   logic [1:0]           l_have;
   logic [W-1:0]         l_a, l_b;
   logic                 do_res, do_err, do_latch;

   // In WAIT the command fields and the already-valid operand come from the latch
   logic                 in_wait;
   logic                 x_mode, x_cin;
   logic [CMD_WIDTH-1:0] x_cmd;
   logic [W-1:0]         x_a, x_b;

   assign in_wait = (state == WAIT);
   assign x_mode  = in_wait ? l_mode : mode;
   assign x_cin   = in_wait ? l_cin  : cin;
   assign x_cmd   = in_wait ? l_cmd  : cmd;
   assign x_a     = (in_wait && l_have[0]) ? l_a : opa;
   assign x_b     = (in_wait && l_have[1]) ? l_b : opb;

   int unsigned   op;
   logic          illegal, need_a, need_b, rot_bad;
   logic [W:0]    ea, eb, one, c_res;
   logic [2*W-1:0] rot;
   logic          c_oflow, c_cout, c_g, c_l, c_e, c_err;

   always_comb begin
      op      = 32'(x_cmd);
      ea      = {1'b0, x_a};
      eb      = {1'b0, x_b};
      one     = {{W{1'b0}}, 1'b1};
      rot_bad = |(x_b >> LW);
      rot     = (op == 13) ? ({x_a, x_a} >> x_b[LW-1:0]) : ({x_a, x_a} << x_b[LW-1:0]);
      illegal = 1'b0;
      need_a  = 1'b1;
      need_b  = 1'b1;
      c_res   = '0;
      c_oflow = 1'b0;
      c_cout  = 1'b0;
      c_g     = 1'b0;
      c_l     = 1'b0;
      c_e     = 1'b0;
      c_err   = 1'b0;
      if (x_mode) begin
         case (op)
            0: begin c_res = ea + eb; c_cout = c_res[W]; end
            1: begin c_res = ea - eb; c_oflow = c_res[W]; end
            2: begin c_res = ea + eb + {{W{1'b0}}, x_cin}; c_cout = c_res[W]; end
            3: begin c_res = ea - eb - {{W{1'b0}}, x_cin}; c_oflow = c_res[W]; end
            4: begin c_res = ea + one; c_cout = c_res[W]; need_b = 1'b0; end
            5: begin c_res = ea - one; c_oflow = c_res[W]; need_b = 1'b0; end
            6: begin c_res = eb + one; c_cout = c_res[W]; need_a = 1'b0; end
            7: begin c_res = eb - one; c_oflow = c_res[W]; need_a = 1'b0; end
            8: begin c_g = (x_a > x_b); c_l = (x_a < x_b); c_e = (x_a == x_b); end
            default: illegal = 1'b1;
         endcase
      end else begin
         case (op)
            0:  c_res = {1'b0, x_a & x_b};
            1:  c_res = {1'b0, ~(x_a & x_b)};
            2:  c_res = {1'b0, x_a | x_b};
            3:  c_res = {1'b0, ~(x_a | x_b)};
            4:  c_res = {1'b0, x_a ^ x_b};
            5:  c_res = {1'b0, ~(x_a ^ x_b)};
            6:  begin c_res = {1'b0, ~x_a};     need_b = 1'b0; end
            7:  begin c_res = {1'b0, ~x_b};     need_a = 1'b0; end
            8:  begin c_res = {1'b0, x_a >> 1}; need_b = 1'b0; end
            9:  begin c_res = {1'b0, x_a << 1}; need_b = 1'b0; end
            10: begin c_res = {1'b0, x_b >> 1}; need_a = 1'b0; end
            11: begin c_res = {1'b0, x_b << 1}; need_a = 1'b0; end
            12: c_res = {1'b0, rot[2*W-1:W]};
            13: c_res = {1'b0, rot[W-1:0]};
            default: illegal = 1'b1;
         endcase
         if ((op == 12 || op == 13) && rot_bad) c_err = 1'b1;
      end
      if (illegal || c_err) begin
         c_res   = '0;
         c_oflow = 1'b0;
         c_cout  = 1'b0;
         c_g     = 1'b0;
         c_l     = 1'b0;
         c_e     = 1'b0;
         c_err   = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      do_res   = 1'b0;
      do_err   = 1'b0;
      do_latch = 1'b0;
      if (ce) begin
         case (state)
            IDLE: begin
               if (illegal) begin
                  do_err = 1'b1;
               end else if ((!need_a || inp_valid[0]) && (!need_b || inp_valid[1])) begin
                  do_res = 1'b1;
               end else if (need_a && need_b && inp_valid != 2'b00) begin
                  do_latch = 1'b1;
                  cnt_nx   = '0;
                  state_nx = WAIT;
               end else begin
                  do_err = 1'b1;
               end
            end
            WAIT: begin
               // A late operand on the final edge takes priority over the timeout
               if (|(inp_valid & ~l_have)) begin
                  do_res   = 1'b1;
                  state_nx = IDLE;
               end else if (cnt >= 4'd15) begin
                  do_err   = 1'b1;
                  state_nx = IDLE;
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         l_cmd  <= '0;
         l_mode <= 1'b0;
         l_cin  <= 1'b0;
         l_have <= '0;
         l_a    <= '0;
         l_b    <= '0;
         res    <= '0;
         oflow  <= 1'b0;
         cout   <= 1'b0;
         g      <= 1'b0;
         l      <= 1'b0;
         e      <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (do_latch) begin
            l_cmd  <= cmd;
            l_mode <= mode;
            l_cin  <= cin;
            l_have <= inp_valid;
            l_a    <= opa;
            l_b    <= opb;
         end
         if (do_res) begin
            res   <= c_res;
            oflow <= c_oflow;
            cout  <= c_cout;
            g     <= c_g;
            l     <= c_l;
            e     <= c_e;
            err   <= c_err;
         end else if (do_err) begin
            res   <= '0;
            oflow <= 1'b0;
            cout  <= 1'b0;
            g     <= 1'b0;
            l     <= 1'b0;
            e     <= 1'b0;
            err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus queues hand-computed expectations,
// a monitor process compares them on the falling edge after the result edge.
module tb_alu_core;

   logic       clk = 1'b0;
   logic       rst, ce, mode, cin;
   logic [1:0] inp_valid;
   logic [3:0] cmd;
   logic [7:0] opa, opb;
   logic [8:0] res;
   logic       oflow, cout, g, l, e, err;

   alu_core #(.DATA_WIDTH(8), .CMD_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin),
      .inp_valid(inp_valid), .cmd(cmd), .opa(opa), .opb(opb),
      .res(res), .oflow(oflow), .cout(cout), .g(g), .l(l), .e(e), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int passed = 0;
   int total  = 0;

   int          due_q[$];
   logic [14:0] val_q[$];
   string       name_q[$];

   function automatic logic [14:0] outv();
      return {res, oflow, cout, g, l, e, err};
   endfunction

   // flag order everywhere: {oflow, cout, g, l, e, err}
   task automatic chk(input string n, input logic [14:0] act, input logic [14:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got res=%h flags=%b, required res=%h flags=%b",
                    n, act[14:6], act[5:0], exp[14:6], exp[5:0]);
   endtask

   task automatic drive(input logic c, input logic m, input logic [3:0] cm, input logic ci,
                        input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      ce = c; mode = m; cmd = cm; cin = ci; inp_valid = iv; opa = a; opb = b;
   endtask

   task automatic expect_next(input string n, input logic [8:0] r, input logic [5:0] f);
      due_q.push_back(cyc + 1);
      val_q.push_back({r, f});
      name_q.push_back(n);
   endtask

   initial begin
      int          d;
      logic [14:0] v;
      string       n;
      forever begin
         @(negedge clk);
         while (due_q.size() > 0 && due_q[0] <= cyc) begin
            d = due_q.pop_front();
            v = val_q.pop_front();
            n = name_q.pop_front();
            chk(n, outv(), v);
         end
      end
   end

   initial begin
      int act;
      rst = 1'b1; ce = 1'b0; mode = 1'b0; cmd = 4'd0; cin = 1'b0;
      inp_valid = 2'b00; opa = 8'h00; opb = 8'h00;
      #12;
      chk("reset_state", outv(), 15'h0000);
      @(negedge clk);
      rst = 1'b0;

      drive(1'b1, 1'b1, 4'd3, 1'b1, 2'b11, 8'h05, 8'h05); expect_next("sub_cin", 9'h1FF, 6'b100000);
      drive(1'b1, 1'b1, 4'd8, 1'b0, 2'b11, 8'h10, 8'h20); expect_next("cmp_lt", 9'h000, 6'b000100);
      drive(1'b1, 1'b0, 4'd12, 1'b0, 2'b11, 8'h81, 8'h01); expect_next("rol", 9'h003, 6'b000000);
      drive(1'b1, 1'b0, 4'd12, 1'b0, 2'b11, 8'h81, 8'h10); expect_next("rol_bad_amt", 9'h000, 6'b000001);
      drive(1'b1, 1'b0, 4'd13, 1'b0, 2'b11, 8'h81, 8'h03); expect_next("ror", 9'h030, 6'b000000);
      drive(1'b1, 1'b0, 4'd1, 1'b0, 2'b11, 8'hF0, 8'h3C); expect_next("nand", 9'h0CF, 6'b000000);
      drive(1'b0, 1'b1, 4'd0, 1'b0, 2'b11, 8'hFF, 8'hFF); expect_next("ce_low_hold", 9'h0CF, 6'b000000);
      drive(1'b1, 1'b0, 4'd11, 1'b0, 2'b10, 8'h00, 8'h81); expect_next("shl1_b", 9'h002, 6'b000000);
      drive(1'b1, 1'b1, 4'd7, 1'b0, 2'b10, 8'h00, 8'h00); expect_next("dec_b_wrap", 9'h1FF, 6'b100000);
      drive(1'b1, 1'b1, 4'd2, 1'b1, 2'b11, 8'hFF, 8'h00); expect_next("add_cin", 9'h100, 6'b010000);

      // operand wait: XOR latched, operand B arrives five edges later with cmd changed
      drive(1'b1, 1'b0, 4'd4, 1'b0, 2'b01, 8'hF0, 8'h00); expect_next("wait_hold", 9'h100, 6'b010000);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'd4, 1'b0, 2'b00, 8'h00, 8'h00);
      drive(1'b1, 1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'h3C); expect_next("wait_xor", 9'h0CC, 6'b000000);

      // timeout: 16 active edges, ce low on cycles 3-6
      drive(1'b1, 1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'h55);
      act = 0;
      for (int i = 1; i <= 20; i++) begin
         drive((i >= 3 && i <= 6) ? 1'b0 : 1'b1, 1'b1, 4'd5, 1'b0, 2'b00, 8'h00, 8'h00);
         if (!(i >= 3 && i <= 6)) act++;
         if (act == 15 && !(i >= 3 && i <= 6)) expect_next("timeout_not_early", 9'h0CC, 6'b000000);
         if (act == 16 && !(i >= 3 && i <= 6)) expect_next("timeout_err", 9'h000, 6'b000001);
      end

      // operand arriving on the 16th edge beats the timeout
      drive(1'b1, 1'b0, 4'd2, 1'b0, 2'b01, 8'h0F, 8'h00); expect_next("late_latch_hold", 9'h000, 6'b000001);
      for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'd2, 1'b0, 2'b00, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 4'd2, 1'b0, 2'b10, 8'h00, 8'hF0); expect_next("late_operand_wins", 9'h0FF, 6'b000000);

      drive(1'b1, 1'b1, 4'd9, 1'b0, 2'b11, 8'h01, 8'h01); expect_next("illegal_arith", 9'h000, 6'b000001);
      drive(1'b1, 1'b1, 4'd4, 1'b0, 2'b01, 8'hFF, 8'h00); expect_next("inc_a_clears", 9'h100, 6'b010000);
      drive(1'b1, 1'b0, 4'd15, 1'b0, 2'b11, 8'h01, 8'h01); expect_next("illegal_logic", 9'h000, 6'b000001);
      drive(1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 8'h01, 8'h01); expect_next("no_operands", 9'h000, 6'b000001);
      drive(1'b1, 1'b0, 4'd6, 1'b0, 2'b10, 8'h01, 8'h01); expect_next("not_a_missing", 9'h000, 6'b000001);
      drive(1'b1, 1'b1, 4'd6, 1'b0, 2'b10, 8'h00, 8'h10); expect_next("inc_b", 9'h011, 6'b000000);

      // asynchronous reset in the middle of a pending SUB wait
      drive(1'b1, 1'b1, 4'd1, 1'b0, 2'b01, 8'h05, 8'h00); expect_next("pre_reset_hold", 9'h011, 6'b000000);
      drive(1'b1, 1'b1, 4'd1, 1'b0, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", outv(), 15'h0000);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b1, 4'd0, 1'b0, 2'b11, 8'hFF, 8'h01); expect_next("post_reset_add", 9'h100, 6'b010000);

      for (int i = 0; i < 20 && due_q.size() > 0; i++) @(negedge clk);
      if (due_q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, required 0", due_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
